// File: rtl/rdseq_pkg.sv
// rdseq_pkg -- shared definitions for the read sequencer.
//   rdseq_state_t : FSM state encoding (IDLE, READ, HOLD, DONE)
//   DEF_ADDR_W    : default address width of the read interface
//   DEF_DATA_W    : default data width of the read interface
package rdseq_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } rdseq_state_t;

endpackage

// File: rtl/read_sequencer.sv
// read_sequencer -- issues a burst of reads to a combinational responder and
// hands each word to a valid/ready consumer, keeping a running checksum.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (aborts any burst, no done pulse)
//   start      burst request, only looked at while idle
//   base       first address of the burst (sampled with start)
//   count      words to read, 0..2^ADDR_W (sampled with start)
//   mem_addr   address to the responder, always the current read address
//   mem_data   responder data, valid in the same cycle as mem_addr
//   out_valid  out_data/out_addr hold a captured word
//   out_ready  consumer accepts the word when out_valid && out_ready
//   out_data   captured read data
//   out_addr   address the captured word came from
//   busy       high whenever not idle
//   done       one-cycle pulse when a burst completes
//   sum        checksum of accepted words, modulo 2^DATA_W
module read_sequencer
  import rdseq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum
);

  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(1);

  rdseq_state_t      r_state;
  logic [ADDR_W-1:0] r_addr;
  // One bit wider than the address so a full 2^ADDR_W burst fits.
  logic [ADDR_W:0]   r_remaining;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_sum;
  logic              r_busy;
  logic              r_done;

  // busy and done are registered alongside the state transition so they
  // always match the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_sum       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sum  <= '0;
            r_busy <= 1'b1;
            if (count != '0) begin
              r_addr      <= base;
              r_remaining <= count;
              r_state     <= ST_READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_READ: begin
          // Responder is combinational: capture its answer this cycle.
          r_out_data  <= mem_data;
          r_out_addr  <= r_addr;
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_sum       <= r_sum + r_out_data;
            if (r_remaining == REM_ONE) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_addr      <= r_addr + ADDR_INC;
              r_remaining <= r_remaining - REM_ONE;
              r_state     <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;

endmodule
